// File: rtl/adder_pipe.sv
// Segmented carry-pipelined adder/subtractor: stage k adds SEG bits and hands its
// carry to stage k+1, with optional unsigned saturation applied in the last stage.
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sm,
    output logic             co,
    output logic             sm_zero
);

    localparam int NSEG = WIDTH / SEG;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The whole pipeline freezes while the last stage holds a result nobody takes,
    // so in_ready is simply the inverse of that stall condition.

    logic             r_valid [NSEG];
    logic [WIDTH-1:0] r_sum   [NSEG];
    logic [WIDTH-1:0] r_x     [NSEG];
    logic [WIDTH-1:0] r_y     [NSEG];
    logic             r_c     [NSEG];
    logic             r_sub   [NSEG];
    logic             r_sat   [NSEG];
    logic             r_zero;

    logic             w_valid_in [NSEG];
    logic [WIDTH-1:0] w_sum_in   [NSEG];
    logic [WIDTH-1:0] w_x_in     [NSEG];
    logic [WIDTH-1:0] w_y_in     [NSEG];
    logic             w_c_in     [NSEG];
    logic             w_sub_in   [NSEG];
    logic             w_sat_in   [NSEG];
    logic [WIDTH-1:0] w_sum_nx   [NSEG];
    logic             w_c_nx     [NSEG];
    logic [SEG:0]     w_seg;
    logic             w_zero_nx;
    logic             w_stall;

    assign w_stall   = r_valid[NSEG-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[NSEG-1];
    assign sm        = r_sum[NSEG-1];
    assign co        = r_c[NSEG-1];
    assign sm_zero   = r_zero;

    // Subtract is folded into stage 0 as x + ~y + 1, so later stages only add.
    always_comb begin
        w_valid_in[0] = in_valid;
        w_sum_in[0]   = '0;
        w_x_in[0]     = x;
        w_y_in[0]     = sub ? ~y : y;
        w_c_in[0]     = sub | cin;
        w_sub_in[0]   = sub;
        w_sat_in[0]   = sat;
        for (int k = 1; k < NSEG; k++) begin
            w_valid_in[k] = r_valid[k-1];
            w_sum_in[k]   = r_sum[k-1];
            w_x_in[k]     = r_x[k-1];
            w_y_in[k]     = r_y[k-1];
            w_c_in[k]     = r_c[k-1];
            w_sub_in[k]   = r_sub[k-1];
            w_sat_in[k]   = r_sat[k-1];
        end
    end

    always_comb begin
        w_seg     = '0;
        w_zero_nx = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            w_seg = {1'b0, w_x_in[k][k*SEG +: SEG]}
                  + {1'b0, w_y_in[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, w_c_in[k]};
            w_sum_nx[k]                = w_sum_in[k];
            w_sum_nx[k][k*SEG +: SEG]  = w_seg[SEG-1:0];
            w_c_nx[k]                  = w_seg[SEG];
            if (k == NSEG - 1) begin
                // Final carry becomes a borrow for subtract; saturation keys off it.
                w_c_nx[k] = w_seg[SEG] ^ w_sub_in[k];
                if (w_sat_in[k] && w_c_nx[k])
                    w_sum_nx[k] = w_sub_in[k] ? '0 : '1;
                w_zero_nx = (w_sum_nx[k] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                r_valid[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_x[k]     <= '0;
                r_y[k]     <= '0;
                r_c[k]     <= 1'b0;
                r_sub[k]   <= 1'b0;
                r_sat[k]   <= 1'b0;
            end
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < NSEG; k++) begin
                r_valid[k] <= w_valid_in[k];
                r_sum[k]   <= w_sum_nx[k];
                r_x[k]     <= w_x_in[k];
                r_y[k]     <= w_y_in[k];
                r_c[k]     <= w_c_nx[k];
                r_sub[k]   <= w_sub_in[k];
                r_sat[k]   <= w_sat_in[k];
            end
            r_zero <= w_zero_nx;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed corner cases, back-pressure, reset
// mid-flight and random streams on 32/8, 16/16 and 64/16 configurations.
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, cin, sub, sat, out_valid, out_ready, co, sm_zero;
    logic [31:0] x, y, sm;

    logic        s_in_valid, s_in_ready, s_cin, s_sub, s_sat, s_out_valid, s_out_ready, s_co, s_sm_zero;
    logic [15:0] s_x, s_y, s_sm;

    logic        l_in_valid, l_in_ready, l_cin, l_sub, l_sat, l_out_valid, l_out_ready, l_co, l_sm_zero;
    logic [63:0] l_x, l_y, l_sm;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected results packed as {co, sm_zero, sm[63:0]}.
    logic [65:0] exp_q[$];
    logic [65:0] s_exp_q[$];
    logic [65:0] l_exp_q[$];

    adder_pipe #(.WIDTH(32), .SEG(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .sm(sm), .co(co), .sm_zero(sm_zero)
    );

    adder_pipe #(.WIDTH(16), .SEG(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x(s_x), .y(s_y), .cin(s_cin), .sub(s_sub), .sat(s_sat),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .sm(s_sm), .co(s_co), .sm_zero(s_sm_zero)
    );

    adder_pipe #(.WIDTH(64), .SEG(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .x(l_x), .y(l_y), .cin(l_cin), .sub(l_sub), .sat(l_sat),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .sm(l_sm), .co(l_co), .sm_zero(l_sm_zero)
    );

    // Reference: plain wide arithmetic on the operands, then saturation.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic ci, input logic sb, input logic st);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] r;
        logic        c;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        if (!sb) begin
            full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
            c    = full[w];
            r    = full[63:0] & mask;
        end else begin
            c = (a < b);
            r = (a - b) & mask;
        end
        if (st && c) r = sb ? 64'd0 : mask;
        return {c, (r == 64'd0), r};
    endfunction

    function automatic logic [63:0] rnd_val(input int w);
        logic [63:0] v;
        logic [63:0] mask;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = mask;
            default: v = {$urandom, $urandom} & mask;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        in_valid = 0; out_ready = 1; x = 0; y = 0; cin = 0; sub = 0; sat = 0;
        s_in_valid = 0; s_out_ready = 1; s_x = 0; s_y = 0; s_cin = 0; s_sub = 0; s_sat = 0;
        l_in_valid = 0; l_out_ready = 1; l_x = 0; l_y = 0; l_cin = 0; l_sub = 0; l_sat = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (sm !== 32'd0) begin n_fail++; $display("FAIL reset_sm: got %h expected 0", sm); end
        n_tests++; if (co !== 1'b0) begin n_fail++; $display("FAIL reset_co: got %b expected 0", co); end
        n_tests++; if (sm_zero !== 1'b0) begin n_fail++; $display("FAIL reset_sm_zero: got %b expected 0", sm_zero); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (s_out_valid !== 1'b0 || l_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_scaled_out_valid: got %b/%b expected 0/0", s_out_valid, l_out_valid);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_directed();
        logic [31:0] dx [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [31:0] dy [4] = '{32'd0, 32'd0, 32'd7, 32'd7};
        logic        dsb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        dst[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] esm[4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        logic        eco[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic        ezr[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 4; c++) begin
            int lat;
            lat = 0;
            @(negedge clk);
            in_valid = 1; x = dx[c]; y = dy[c]; cin = 1; sub = dsb[c]; sat = dst[c]; out_ready = 1;
            for (int t = 1; t <= 12 && lat == 0; t++) begin
                @(negedge clk);
                in_valid = 0;
                #1;
                if (out_valid) lat = t;
            end
            n_tests++; if (lat != 4) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected 4", c, lat); end
            n_tests++; if (sm !== esm[c]) begin n_fail++; $display("FAIL directed%0d_sm: got %h expected %h", c, sm, esm[c]); end
            n_tests++; if (co !== eco[c]) begin n_fail++; $display("FAIL directed%0d_co: got %b expected %b", c, co, eco[c]); end
            n_tests++; if (sm_zero !== ezr[c]) begin n_fail++; $display("FAIL directed%0d_sm_zero: got %b expected %b", c, sm_zero, ezr[c]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ox[10], oy[10];
        logic        oc[10], ob[10], os[10];
        logic [33:0] held;
        logic        stalled_prev;
        int          sent, got, cyc;
        logic [65:0] e;
        sent = 0; got = 0; cyc = 0; stalled_prev = 0; held = '0;
        for (int i = 0; i < 10; i++) begin
            ox[i] = rnd_val(32); oy[i] = rnd_val(32);
            oc[i] = 1'($urandom_range(0, 1)); ob[i] = 1'($urandom_range(0, 1)); os[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        while (got < 10 && cyc < 60) begin
            @(negedge clk);
            in_valid = (sent < 10);
            if (sent < 10) begin x = ox[sent]; y = oy[sent]; cin = oc[sent]; sub = ob[sent]; sat = os[sent]; end
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            n_tests++; if (in_ready !== !(cyc >= 6 && cyc <= 8)) begin
                n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, !(cyc >= 6 && cyc <= 8));
            end
            if (out_valid && !out_ready) begin
                if (stalled_prev) begin
                    n_tests++; if ({co, sm_zero, sm} !== held) begin
                        n_fail++; $display("FAIL b2b_stall_hold cyc %0d: got %h expected %h", cyc, {co, sm_zero, sm}, held);
                    end
                end
                held = {co, sm_zero, sm};
                stalled_prev = 1;
            end else begin
                stalled_prev = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(32, {32'd0, x}, {32'd0, y}, cin, sub, sat));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_result: got %h expected none", sm);
                end else begin
                    e = exp_q.pop_front();
                    if ({co, sm_zero, sm} !== {e[65], e[64], e[31:0]}) begin
                        n_fail++; $display("FAIL b2b_result %0d: got %h expected %h", got, {co, sm_zero, sm}, {e[65], e[64], e[31:0]});
                    end
                end
                got++;
            end
            cyc++;
        end
        in_valid = 0; out_ready = 1;
        n_tests++; if (got != 10 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results, %0d pending, expected 10 and 0", got, exp_q.size());
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate: got out_valid %b expected 0", out_valid); end
        end
    endtask

    task automatic test_random();
        logic        have;
        int          sent, got, cyc;
        logic [65:0] e;
        have = 0; sent = 0; got = 0; cyc = 0;
        exp_q.delete();
        while ((sent < 40 || got < 40) && cyc < 400) begin
            @(negedge clk);
            if (!have && sent < 40 && $urandom_range(0, 3) != 0) begin
                x = rnd_val(32); y = rnd_val(32);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
                have = 1;
            end
            in_valid = have;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(32, {32'd0, x}, {32'd0, y}, cin, sub, sat));
                sent++; have = 0;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_result: got %h expected none", sm);
                end else begin
                    e = exp_q.pop_front();
                    if ({co, sm_zero, sm} !== {e[65], e[64], e[31:0]}) begin
                        n_fail++; $display("FAIL rand_result %0d: got %h expected %h", got, {co, sm_zero, sm}, {e[65], e[64], e[31:0]});
                    end
                end
                got++;
            end
            cyc++;
        end
        in_valid = 0; out_ready = 1;
        n_tests++; if (got != 40) begin n_fail++; $display("FAIL rand_count: got %0d expected 40", got); end
    endtask

    task automatic test_reset_midflight();
        logic [65:0] e;
        int          lat;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1; x = rnd_val(32); y = rnd_val(32); cin = 1'($urandom_range(0, 1)); sub = 0; sat = 0; out_ready = 0;
        end
        @(negedge clk) in_valid = 0;
        @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
        rst_n = 0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_tests++; if ({co, sm_zero, sm} !== 34'd0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 0", {co, sm_zero, sm}); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk) begin rst_n = 1; out_ready = 1; end
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cyc %0d: got out_valid %b expected 0", t, out_valid); end
        end
        @(negedge clk);
        in_valid = 1; x = rnd_val(32); y = rnd_val(32); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
        e = ref_op(32, {32'd0, x}, {32'd0, y}, cin, sub, sat);
        lat = 0;
        for (int t = 1; t <= 12 && lat == 0; t++) begin
            @(negedge clk);
            in_valid = 0;
            #1;
            if (out_valid) lat = t;
        end
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
        n_tests++; if ({co, sm_zero, sm} !== {e[65], e[64], e[31:0]}) begin
            n_fail++; $display("FAIL midrst_result: got %h expected %h", {co, sm_zero, sm}, {e[65], e[64], e[31:0]});
        end
    endtask

    task automatic test_scaling();
        logic [65:0] se, le, e;
        int          s_lat, l_lat, s_sent, s_got, l_sent, l_got, cyc;
        logic        s_have, l_have;
        @(negedge clk);
        s_in_valid = 1; s_x = 16'(rnd_val(16)); s_y = 16'(rnd_val(16)); s_cin = 1; s_sub = 0; s_sat = 1;
        l_in_valid = 1; l_x = rnd_val(64); l_y = rnd_val(64); l_cin = 1; l_sub = 1; l_sat = 0;
        se = ref_op(16, {48'd0, s_x}, {48'd0, s_y}, s_cin, s_sub, s_sat);
        le = ref_op(64, l_x, l_y, l_cin, l_sub, l_sat);
        s_lat = 0; l_lat = 0;
        for (int t = 1; t <= 12 && (s_lat == 0 || l_lat == 0); t++) begin
            @(negedge clk);
            s_in_valid = 0; l_in_valid = 0;
            #1;
            if (s_out_valid && s_lat == 0) begin
                s_lat = t;
                n_tests++; if ({s_co, s_sm_zero, s_sm} !== {se[65], se[64], se[15:0]}) begin
                    n_fail++; $display("FAIL w16_first_result: got %h expected %h", {s_co, s_sm_zero, s_sm}, {se[65], se[64], se[15:0]});
                end
            end
            if (l_out_valid && l_lat == 0) begin
                l_lat = t;
                n_tests++; if ({l_co, l_sm_zero, l_sm} !== le) begin
                    n_fail++; $display("FAIL w64_first_result: got %h expected %h", {l_co, l_sm_zero, l_sm}, le);
                end
            end
        end
        n_tests++; if (s_lat != 1) begin n_fail++; $display("FAIL w16_latency: got %0d expected 1", s_lat); end
        n_tests++; if (l_lat != 4) begin n_fail++; $display("FAIL w64_latency: got %0d expected 4", l_lat); end

        s_exp_q.delete(); l_exp_q.delete();
        s_have = 0; l_have = 0; s_sent = 0; s_got = 0; l_sent = 0; l_got = 0; cyc = 0;
        while ((s_got < 40 || l_got < 40) && cyc < 500) begin
            @(negedge clk);
            if (!s_have && s_sent < 40 && $urandom_range(0, 3) != 0) begin
                s_x = 16'(rnd_val(16)); s_y = 16'(rnd_val(16));
                s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1)); s_sat = 1'($urandom_range(0, 1));
                s_have = 1;
            end
            if (!l_have && l_sent < 40 && $urandom_range(0, 3) != 0) begin
                l_x = rnd_val(64); l_y = rnd_val(64);
                l_cin = 1'($urandom_range(0, 1)); l_sub = 1'($urandom_range(0, 1)); l_sat = 1'($urandom_range(0, 1));
                l_have = 1;
            end
            s_in_valid = s_have; l_in_valid = l_have;
            s_out_ready = ($urandom_range(0, 3) != 0);
            l_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (s_in_valid && s_in_ready) begin
                s_exp_q.push_back(ref_op(16, {48'd0, s_x}, {48'd0, s_y}, s_cin, s_sub, s_sat));
                s_sent++; s_have = 0;
            end
            if (l_in_valid && l_in_ready) begin
                l_exp_q.push_back(ref_op(64, l_x, l_y, l_cin, l_sub, l_sat));
                l_sent++; l_have = 0;
            end
            if (s_out_valid && s_out_ready) begin
                n_tests++;
                if (s_exp_q.size() == 0) begin
                    n_fail++; $display("FAIL w16_extra_result: got %h expected none", s_sm);
                end else begin
                    e = s_exp_q.pop_front();
                    if ({s_co, s_sm_zero, s_sm} !== {e[65], e[64], e[15:0]}) begin
                        n_fail++; $display("FAIL w16_result %0d: got %h expected %h", s_got, {s_co, s_sm_zero, s_sm}, {e[65], e[64], e[15:0]});
                    end
                end
                s_got++;
            end
            if (l_out_valid && l_out_ready) begin
                n_tests++;
                if (l_exp_q.size() == 0) begin
                    n_fail++; $display("FAIL w64_extra_result: got %h expected none", l_sm);
                end else begin
                    e = l_exp_q.pop_front();
                    if ({l_co, l_sm_zero, l_sm} !== e) begin
                        n_fail++; $display("FAIL w64_result %0d: got %h expected %h", l_got, {l_co, l_sm_zero, l_sm}, e);
                    end
                end
                l_got++;
            end
            cyc++;
        end
        s_in_valid = 0; l_in_valid = 0;
        n_tests++; if (s_got != 40 || l_got != 40) begin
            n_fail++; $display("FAIL scaling_count: got %0d/%0d expected 40/40", s_got, l_got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_scaling();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand width in bits.
REQ-002 The block SHALL have parameter SEG, default 8, setting the carry-segment width; WIDTH SHALL be an integer multiple of SEG.
REQ-003 The block SHALL have a derived parameter NSEG = WIDTH/SEG, which is both the segment count and the pipeline depth.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-008 The block SHALL have ports x and y, input, WIDTH bits each: unsigned operands.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in, used in add only.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-011 The block SHALL have port sat, input, 1 bit: 1 enables unsigned saturation.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream block accepts the result.
REQ-014 The block SHALL have port sm, output, WIDTH bits: the result.
REQ-015 The block SHALL have port co, output, 1 bit: raw carry-out in add, borrow in subtract, before saturation.
REQ-016 The block SHALL have port sm_zero, output, 1 bit: asserted when sm == 0, evaluated after saturation.

Function
REQ-017 An operand set SHALL be accepted on any rising edge where in_valid and in_ready are both 1.
REQ-018 Add SHALL compute the (WIDTH+1)-bit value x + y + cin; co = bit WIDTH, sm = bits WIDTH-1:0.
REQ-019 Subtract SHALL compute x + ~y + 1, ignoring cin; co = borrow = NOT bit WIDTH, so co = 1 exactly when x < y.
REQ-020 Stage k (k = 0..NSEG-1) SHALL add segment k of the operands, taking the carry registered by stage k-1, so that no combinational carry path exceeds SEG bits.
REQ-021 Each stage SHALL register the sum segments already computed, the upper operand segments not yet added, the carry, and the sub, sat and valid bits.
REQ-022 Saturation (sat = 1) SHALL be applied in the last stage: an add with co = 1 gives sm = all ones; a subtract with co = 1 gives sm = 0; otherwise sm is unchanged.
REQ-023 With sat = 0, sm SHALL wrap modulo 2^WIDTH.
REQ-024 Latency SHALL be exactly NSEG cycles from acceptance to out_valid when there is no stall.
REQ-025 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-026 The pipeline SHALL stall when out_valid = 1 and out_ready = 0; while stalled, all stages hold their contents.
REQ-027 in_ready SHALL equal NOT (out_valid AND NOT out_ready); it is combinational, with no other dependency.
REQ-028 While stalled, sm, co, sm_zero and out_valid SHALL be held stable.
REQ-029 Pipeline bubbles (in_valid = 0) SHALL propagate as valid = 0; outputs with out_valid = 0 are don't-care, but their registers still reset to 0.
REQ-030 Results SHALL leave the block in acceptance order; none is dropped or duplicated.
REQ-031 A result is consumed on an edge where out_valid and out_ready are both 1; if a new result is in the last stage it SHALL appear on the next cycle.
REQ-032 NSEG = 1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-033 When rst_n = 0, out_valid, sm, co, sm_zero and all stage registers (valid bits, data, carries) SHALL be cleared to 0 immediately, without waiting for clk.
REQ-034 With every stage invalid during reset, in_ready SHALL evaluate to 1.
REQ-035 Asserting reset mid-operation SHALL discard all in-flight operations; none SHALL appear after reset release.
REQ-036 The first acceptance SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-037 Check add with carry, WIDTH=32, SEG=8: x=0xFFFFFFFF, y=0, cin=1, sub=0, sat=0 -> 4 cycles later sm=0, co=1, sm_zero=1.
REQ-038 Check add saturation: same operands with sat=1 -> sm=0xFFFFFFFF, co=1, sm_zero=0.
REQ-039 Check subtract underflow: x=5, y=7, sub=1, cin=1 -> sat=0 gives sm=0xFFFFFFFE, co=1; sat=1 gives sm=0, co=1, sm_zero=1.
REQ-040 Check back-pressure: stream 10 random ops back-to-back; drop out_ready for 3 cycles mid-stream -> in_ready low for exactly those cycles, all 10 results in order, no loss or duplication, outputs stable while stalled.
REQ-041 Check reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle -> out_valid=0 at once, no stale result afterwards, next op's result arrives 4 cycles after acceptance.
REQ-042 Check scaling: repeat the random add/sub/sat test against a (WIDTH+1)-bit reference model at WIDTH=16/SEG=16 (latency 1) and WIDTH=64/SEG=16 (latency 4) -> all results match.
